// File: rtl/sram_word_controller.sv
// Sequences a 32-bit load/store onto a 16-bit asynchronous SRAM as two
// half-word phases (low, then high), each held for WAIT_CYCLES clocks.
module sram_word_controller #(
  parameter int          WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [16:0] word;
  logic [31:0] wdata;
  logic        op_wr;
  logic        start;
  logic        phase_end;
  logic        hi;
  logic [16:0] word_nxt;

  // Out-of-range addresses wrap into the 17-bit word space; no error is raised.
  assign word_nxt  = 17'((address - BASE_ADDR) >> 2);
  assign start     = rd_en | wr_en;
  assign phase_end = (cnt == 4'(WAIT_CYCLES - 1));
  assign hi        = (state == ACC_HI);
  assign ready     = ((state == IDLE) && !start) || (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACC_LO;
      ACC_LO:  if (phase_end) state_nxt = ACC_HI;
      ACC_HI:  if (phase_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is latched once; later changes on the inputs are ignored until IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      word      <= '0;
      wdata     <= '0;
      op_wr     <= 1'b0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          word  <= word_nxt;
          wdata <= write_data;
          op_wr <= wr_en;
          cnt   <= '0;
        end
        ACC_LO, ACC_HI: begin
          cnt <= phase_end ? 4'd0 : cnt + 4'd1;
          if (phase_end && !op_wr) begin
            if (hi) read_data[31:16] <= sram_dq_in;
            else    read_data[15:0]  <= sram_dq_in;
          end
        end
        default: ;
      endcase
    end
  end

  // Bus pins decode only registered state, so they move on clock edges only.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    if (state == ACC_LO || state == ACC_HI) begin
      sram_addr = {word, hi};
      if (op_wr) begin
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = hi ? wdata[31:16] : wdata[15:0];
      end
    end
  end

endmodule

// File: tb/tb_sram_word_controller.sv
// Bench for sram_word_controller: directed vector table, reset corner cases and
// randomized accesses against a word-level memory model.
module tb_sram_word_controller;

  localparam int W = 3;

  logic        clk, rst, wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready, sram_dq_oe, sram_we_n;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;

  int n_chk = 0;
  int n_fail = 0;

  sram_word_controller #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical half-word SRAM (aliased to 2048 entries).
  logic [15:0] mem [0:2047];
  assign sram_dq_in = mem[sram_addr[10:0]];
  always @(posedge clk) if (!sram_we_n) mem[sram_addr[10:0]] = sram_dq_out;

  // Reference: word-granular memory and the expected read_data register.
  logic [31:0] model_mem [0:1023];
  logic [31:0] model_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called one step after a rising edge; that cycle is cycle 0 of the access.
  task automatic access(input bit r, input bit wv, input logic [31:0] a,
                        input logic [31:0] d, input bit scr, output logic [17:0] lo_seen);
    logic [16:0] w;
    bit          h;
    w = 17'((a - 32'd1024) >> 2);
    lo_seen = '0;
    if (wv) model_mem[w[9:0]] = d;
    else    model_rd = model_mem[w[9:0]];
    rd_en = r; wr_en = wv; address = a; write_data = d;
    for (int c = 0; c <= 2*W+1; c++) begin
      @(negedge clk);
      chk("ready", 32'(ready), 32'(c == 2*W+1));
      if (c == 0 || c == 2*W+1) begin
        chk("idle_addr", 32'(sram_addr), 32'd0);
        chk("idle_we_n", 32'(sram_we_n), 32'd1);
        chk("idle_oe", 32'(sram_dq_oe), 32'd0);
      end else begin
        h = (c > W);
        if (c == 1) lo_seen = sram_addr;
        chk("acc_addr", 32'(sram_addr), 32'({w, h}));
        chk("acc_we_n", 32'(sram_we_n), 32'(!wv));
        chk("acc_oe", 32'(sram_dq_oe), 32'(wv));
        if (wv) chk("acc_dq", 32'(sram_dq_out), 32'(h ? d[31:16] : d[15:0]));
      end
      if (c == 2*W+1) chk("read_data", read_data, model_rd);
      @(posedge clk); #1;
      if (c == 0 && scr) begin
        rd_en = 1'b0; wr_en = 1'b0; address = 32'd2000; write_data = $urandom;
      end
    end
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    bit          scr;
    logic [17:0] exp_hw;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        tbl [7];
  logic [17:0] lo;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;
    model_rd = '0;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;

    tbl[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, 18'd2,       32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        1'b0, 18'd2,       32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0, 18'd0,       32'hDEADBEEF};
    tbl[3] = '{1'b1, 1'b0, 32'd1024, 32'h0,        1'b0, 18'd0,       32'h12345678};
    tbl[4] = '{1'b0, 1'b1, 32'd0,    32'hA5A55A5A, 1'b0, 18'h3FE00,   32'h12345678};
    tbl[5] = '{1'b1, 1'b0, 32'd3,    32'h0,        1'b0, 18'h3FE00,   32'hA5A55A5A};
    tbl[6] = '{1'b1, 1'b0, 32'd1028, 32'h0,        1'b1, 18'd2,       32'hDEADBEEF};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq", 32'(sram_dq_out), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      access(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].scr, lo);
      chk($sformatf("vec%0d_hw", i), 32'(lo), 32'(tbl[i].exp_hw));
      chk($sformatf("vec%0d_rd", i), read_data, tbl[i].exp_rd);
    end
    chk("sram_lo_0", 32'(mem[0]), 32'h5678);
    chk("sram_hi_1", 32'(mem[1]), 32'h1234);

    // Reset in cycle 2 of a write to word 700.
    wr_en = 1'b1; address = 32'd3824; write_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_we_n", 32'(sram_we_n), 32'd0);
    @(posedge clk); #1;
    wr_en = 1'b0; rst = 1'b1;
    #1;
    chk("arst_we_n", 32'(sram_we_n), 32'd1);
    chk("arst_oe", 32'(sram_dq_oe), 32'd0);
    chk("arst_addr", 32'(sram_addr), 32'd0);
    chk("arst_rdata", read_data, 32'd0);
    chk("arst_ready", 32'(ready), 32'd1);
    model_rd = '0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, lo);

    // Randomized traffic with optional idle gaps.
    for (int i = 0; i < 40; i++) begin
      int          gap;
      logic [31:0] a;
      bit          r, wv;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("gap_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
      end
      wv = ($urandom_range(0, 2) == 0);
      r  = !wv || ($urandom_range(0, 3) == 0);
      a  = 32'd1024 + 32'($urandom_range(0, 511)) * 4 + 32'($urandom_range(0, 3));
      access(r, wv, a, $urandom, bit'($urandom_range(0, 1)), lo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_word_controller.md
# sram_word_controller

Multi-cycle memory-stage controller that sequences 32-bit LDR/STR accesses from the pipeline's MEM stage onto an external 16-bit asynchronous SRAM. Each word access is split into two half-word phases (low half, then high half), each held for a fixed number of wait cycles. While an access is in flight, `ready` stays low, and the hazard/freeze logic uses it to stall every pipeline register. The block sits between the MEM stage (driven by `mem_r_en`/`mem_w_en` from decode) and the SRAM pins.

## Interface
- `WAIT_CYCLES`, default 3: cycles each half-word phase is held on the SRAM bus; legal range 1..15.
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `wr_en` in 1: store request (MEM-stage `mem_w_en`).
- `rd_en` in 1: load request (MEM-stage `mem_r_en`).
- `address` in 32: byte address from the ALU result.
- `write_data` in 32: store data (Rm value).
- `read_data` out 32: last completed load word.
- `ready` out 1: high means no access is pending and the pipeline may advance.
- `sram_addr` out 18: SRAM half-word address.
- `sram_dq_out` out 16: data driven to SRAM on writes.
- `sram_dq_in` in 16: data returned from SRAM.
- `sram_dq_oe` out 1: tri-state enable for `sram_dq_out` (the top level builds the inout).
- `sram_we_n` out 1: SRAM write strobe, active-low.

## Operation
- Word index: `w = (address - BASE_ADDR) >> 2`, 32-bit subtraction with wrap.
  - Low bits `w[16:0]` are used; upper bits are dropped silently.
  - No range error is raised.
  - `address[1:0]` is ignored, so only word-aligned access is supported.
- Half-word addresses: low half at `{w[16:0],1'b0}`, high half at `{w[16:0],1'b1}`.
- FSM states: IDLE, ACC_LO, ACC_HI, DONE. There is a phase counter `cnt` of 4 bits.
- IDLE transitions:
  - If `wr_en` or `rd_en` is high: latch `w`, `write_data`, and op, clear `cnt`, go to ACC_LO.
  - Both `wr_en` and `rd_en` high: treated as a write; the read is ignored.
- ACC_LO transitions:
  - `cnt` increments each cycle.
  - When `cnt == WAIT_CYCLES-1`: clear `cnt`, go to ACC_HI.
  - On a read, capture `sram_dq_in` into `read_data[15:0]` on that same edge.
- ACC_HI: same as ACC_LO, but captures `read_data[31:16]` and goes to DONE.
- DONE: one cycle, then unconditionally to IDLE.
- Output decoding in ACC_LO/ACC_HI:
  - `sram_addr` is the half-word address for the phase.
  - For a write: `sram_we_n` = 0, `sram_dq_oe` = 1, and `sram_dq_out` = latched `write_data[15:0]` (LO) or `[31:16]` (HI).
  - For a read: `sram_we_n` = 1, `sram_dq_oe` = 0.
- Output decoding in IDLE/DONE: `sram_addr` = 0, `sram_we_n` = 1, `sram_dq_oe` = 0, `sram_dq_out` = 0.
- `ready` (combinational): `(IDLE && !rd_en && !wr_en) || DONE`.
- `read_data` is registered. It updates only during read phases and otherwise holds its value. Writes never modify it.
- Inputs are latched at the IDLE→ACC_LO edge. Deasserting `rd_en`/`wr_en` or changing `address`/`write_data` mid-access has no effect, and the access always completes.

## Timing
- Request sampled high in IDLE at cycle 0. ACC_LO occupies cycles 1..W, ACC_HI occupies W+1..2W, DONE is cycle 2W+1 (W = `WAIT_CYCLES`).
- `ready` is low from cycle 0 through 2W and high in cycle 2W+1.
  - The pipeline advances on the edge closing cycle 2W+1.
  - Default W = 3 gives a stall of 7 cycles and advance at the end of cycle 7.
- `read_data` is valid from cycle 2W+1 onward (already updated when DONE is entered).
- Back-to-back requests: a new request present in the cycle after DONE starts a new access immediately, with no idle gap beyond that cycle.
- `sram_addr`, `sram_we_n`, and `sram_dq_oe` change only on clock edges (decoded from registered state), so they are glitch-free relative to the phase.
- Reset values: state IDLE, `cnt` 0, `read_data` 0, `sram_addr` 0, `sram_dq_out` 0, `sram_dq_oe` 0, `sram_we_n` 1. `ready` follows `!(rd_en|wr_en)`.
- Reset asserted mid-access:
  - Immediately (asynchronously) force IDLE, `sram_we_n` 1, `sram_dq_oe` 0, `read_data` 0.
  - The partial SRAM write is abandoned and not retried.

## Test plan
- Reset, no requests: `ready` = 1, `sram_we_n` = 1, `sram_dq_oe` = 0, `read_data` = 0.
- Write with W=3: `wr_en` = 1, `address` = 1028, `write_data` = 0xDEADBEEF.
  - Cycles 1-3: `sram_addr` = 2, `sram_dq_out` = 0xBEEF, `we_n` = 0.
  - Cycles 4-6: `sram_addr` = 3, `sram_dq_out` = 0xDEAD.
  - `ready` high only in cycle 7.
- Read back with an SRAM model: `rd_en` = 1, `address` = 1028 → `read_data` = 0xDEADBEEF in cycle 7, `we_n` stays 1 throughout, `oe` stays 0.
- Simultaneous `rd_en` = `wr_en` = 1, `address` = 1024, data 0x12345678 → write performed to half-words 0/1, and `read_data` is unchanged.
- Request dropped at cycle 2 and `address` changed to 2000 → access to half-words 2/3 still completes, and `ready` rises in cycle 7.
- `rst` pulsed in cycle 2 of a write → outputs return to reset values in the same cycle, and the next `rd_en` starts a clean 7-cycle access.
